// File: rtl/button_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : button_ctrl_pkg
// Description : Shared state encoding and default constants for the
//               push-button conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
package button_ctrl_pkg;

  // ~1.31 ms sample period at a 100 MHz clock
  localparam int TICK_BITS_DEF  = 17;
  // Equal consecutive samples needed to accept a press or a release
  localparam int DB_SAMPLES_DEF = 4;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } db_state_t;

endpackage : button_ctrl_pkg
`default_nettype wire

// File: rtl/debounce_onepulse.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : debounce_onepulse
// Description : One button channel: 2-FF synchronizer, tick-sampled debounce
//               FSM, one-clock press pulse and a toggle level.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_onepulse
  import button_ctrl_pkg::*;
#(
  parameter int DB_SAMPLES = DB_SAMPLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic tick,
  output logic btn_db,
  output logic btn_pulse,
  output logic btn_level
);

  localparam int              CNT_W    = $clog2(DB_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_SAMPLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync_meta;
  logic             sync;
  db_state_t        state;
  db_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             pulse_nxt;

  // Bring the asynchronous button into the clock domain; only sync is used
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= btn_raw;
      sync      <= sync_meta;
    end
  end

  // Debounce state and run counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RELEASED;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: evaluated only on sample ticks, otherwise hold
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse_nxt = 1'b0;
    if (tick) begin
      unique case (state)
        RELEASED: begin
          if (sync) begin
            state_nxt = PRESS_CHK;
            cnt_nxt   = CNT_ONE;
          end
        end
        PRESS_CHK: begin
          if (!sync) begin
            state_nxt = RELEASED;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
            pulse_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!sync) begin
            state_nxt = RELEASE_CHK;
            cnt_nxt   = CNT_ONE;
          end
        end
        RELEASE_CHK: begin
          // A bounce back to 1 returns to HELD without a new pulse
          if (sync) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = RELEASED;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Registered outputs; level toggles on the edge that ends the pulse cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_db    <= 1'b0;
      btn_pulse <= 1'b0;
      btn_level <= 1'b0;
    end else begin
      btn_db    <= (state_nxt == HELD) || (state_nxt == RELEASE_CHK);
      btn_pulse <= pulse_nxt;
      btn_level <= btn_level ^ btn_pulse;
    end
  end

endmodule : debounce_onepulse
`default_nettype wire

// File: rtl/button_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : button_ctrl
// Description : Push-button conditioner: shared sample-tick counter feeding
//               one debounce/one-pulse channel per button.
// Revision    : 1.0 - initial release
// ============================================================================
module button_ctrl
  import button_ctrl_pkg::*;
#(
  parameter int N_BTN      = 2,
  parameter int TICK_BITS  = TICK_BITS_DEF,
  parameter int DB_SAMPLES = DB_SAMPLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_db,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_level
);

  logic [TICK_BITS-1:0] tick_cnt;
  logic                 tick;

  // Free-running sample counter shared by every channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_BITS'(1);
    end
  end

  assign tick = &tick_cnt;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    debounce_onepulse #(
      .DB_SAMPLES (DB_SAMPLES)
    ) u_db (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw[g]),
      .tick      (tick),
      .btn_db    (btn_db[g]),
      .btn_pulse (btn_pulse[g]),
      .btn_level (btn_level[g])
    );
  end

endmodule : button_ctrl
`default_nettype wire
